// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared types and constants for the execute stage.
//   - AluOpBus / AluSelBus / RegBus widths and their typedefs
//   - aluop and alusel codes used by ex_stage, including the divide and HI/LO moves
//   - divider FSM state encoding
//   - mag(): conditional two's-complement negate, used for |x| and sign fix-up
package ex_stage_pkg;

    localparam int unsigned AluOpW   = 8;
    localparam int unsigned AluSelW  = 3;
    localparam int unsigned RegW     = 32;
    localparam int unsigned RegAddrW = 5;

    typedef logic [AluOpW-1:0]   alu_op_t;
    typedef logic [AluSelW-1:0]  alu_sel_t;
    typedef logic [RegW-1:0]     reg_t;
    typedef logic [RegAddrW-1:0] reg_addr_t;

    // aluop codes
    localparam alu_op_t EXE_NOP_OP  = 8'b0000_0000;
    localparam alu_op_t EXE_AND_OP  = 8'b0010_0100;
    localparam alu_op_t EXE_OR_OP   = 8'b0010_0101;
    localparam alu_op_t EXE_XOR_OP  = 8'b0010_0110;
    localparam alu_op_t EXE_NOR_OP  = 8'b0010_0111;
    localparam alu_op_t EXE_LUI_OP  = 8'b0101_1100;
    localparam alu_op_t EXE_SLL_OP  = 8'b0111_1100;
    localparam alu_op_t EXE_SRL_OP  = 8'b0000_0010;
    localparam alu_op_t EXE_SRA_OP  = 8'b0000_0011;
    localparam alu_op_t EXE_MFHI_OP = 8'b0001_0000;
    localparam alu_op_t EXE_MFLO_OP = 8'b0001_0010;
    localparam alu_op_t EXE_DIV_OP  = 8'b0001_1010;
    localparam alu_op_t EXE_DIVU_OP = 8'b0001_1011;

    // alusel result classes
    localparam alu_sel_t EXE_RES_NOP   = 3'b000;
    localparam alu_sel_t EXE_RES_LOGIC = 3'b001;
    localparam alu_sel_t EXE_RES_SHIFT = 3'b010;
    localparam alu_sel_t EXE_RES_MOVE  = 3'b011;

    // divider FSM states
    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StDivZero = 2'b01,
        StOn      = 2'b10,
        StEnd     = 2'b11
    } div_state_e;

    // Returns -v when neg is set, v otherwise.
    function automatic reg_t mag(input reg_t v, input logic neg);
        return neg ? (~v + reg_t'(1)) : v;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: id/ex operands in, ex/mem write-back triple and HI/LO write out.
//   master: the side driving the id/ex register contents (pipeline / testbench)
//   slave : ex_stage itself
interface ex_stage_if;
    import ex_stage_pkg::*;

    logic      flush_i;
    alu_op_t   aluop_i;
    alu_sel_t  alusel_i;
    reg_t      reg1_i;
    reg_t      reg2_i;
    reg_addr_t wd_i;
    logic      wreg_i;
    reg_t      hi_i;
    reg_t      lo_i;
    logic      mem_whilo_i;
    reg_t      mem_hi_i;
    reg_t      mem_lo_i;

    reg_addr_t wd_o;
    logic      wreg_o;
    reg_t      wdata_o;
    logic      whilo_o;
    reg_t      hi_o;
    reg_t      lo_o;
    logic      stallreq_o;

    modport master (
        output flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
               hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
               hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

endinterface

// File: rtl/ex_stage_div.sv
// div_unit: iterative restoring divider, one quotient bit per cycle.
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : a DIV/DIVU sits in id/ex (sampled only in StIdle)
//   signed_i    : DIV (signed) rather than DIVU
//   divzero_i   : divisor is zero
//   flush_i     : abandon the division in flight
//   dividend_i, divisor_i : operands, latched on the start cycle
//   stall_o     : pipeline hold request
//   ready_o     : result valid (StEnd only)
//   quot_o, rem_o : quotient / remainder, meaningful while ready_o
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic signed_i,
    input  logic divzero_i,
    input  logic flush_i,
    input  reg_t dividend_i,
    input  reg_t divisor_i,
    output logic stall_o,
    output logic ready_o,
    output reg_t quot_o,
    output reg_t rem_o
);

    localparam int unsigned CntW = $clog2(DIV_CYCLES + 1);

    div_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // quot_q starts as |dividend| and is shifted left into the quotient.
    reg_t            quot_q, quot_d;
    reg_t            rem_q, rem_d;
    reg_t            divisor_q, divisor_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    logic [RegW:0] rem_sh;
    logic [RegW:0] diff;
    reg_t          step_rem;
    reg_t          step_quot;

    always_comb begin
        rem_sh = {rem_q, quot_q[RegW-1]};
        diff   = rem_sh - {1'b0, divisor_q};
        if (!diff[RegW]) begin
            step_rem  = diff[RegW-1:0];
            step_quot = {quot_q[RegW-2:0], 1'b1};
        end else begin
            step_rem  = rem_sh[RegW-1:0];
            step_quot = {quot_q[RegW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (divzero_i) begin
                        state_d = StDivZero;
                    end else begin
                        quot_d     = mag(dividend_i, signed_i & dividend_i[RegW-1]);
                        divisor_d  = mag(divisor_i, signed_i & divisor_i[RegW-1]);
                        rem_d      = '0;
                        neg_quot_d = signed_i & (dividend_i[RegW-1] ^ divisor_i[RegW-1]);
                        neg_rem_d  = signed_i & dividend_i[RegW-1];
                        cnt_d      = '0;
                        state_d    = StOn;
                    end
                end
            end
            StDivZero: begin
                quot_d  = '0;
                rem_d   = '0;
                state_d = StEnd;
            end
            StOn: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(DIV_CYCLES - 1)) begin
                    // Last bit: fold the sign correction into the same cycle.
                    quot_d  = mag(step_quot, neg_quot_q);
                    rem_d   = mag(step_rem, neg_rem_q);
                    state_d = StEnd;
                end else begin
                    quot_d = step_quot;
                    rem_d  = step_rem;
                end
            end
            StEnd: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_comb begin
        stall_o = 1'b0;
        ready_o = 1'b0;
        case (state_q)
            StIdle:    stall_o = start_i;
            StDivZero: stall_o = 1'b1;
            StOn:      stall_o = 1'b1;
            StEnd:     ready_o = 1'b1;
            default:   stall_o = 1'b0;
        endcase
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage.
//   clk, rst : clock, synchronous active-high reset (all outputs forced to 0)
//   ex_if    : slave side of ex_stage_if
//     in : flush_i, aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i,
//          hi_i, lo_i, mem_whilo_i, mem_hi_i, mem_lo_i
//     out: wd_o, wreg_o, wdata_o (ex/mem + decode bypass),
//          whilo_o, hi_o, lo_o (HI/LO write), stallreq_o
// Logic/shift/move ops are combinational; DIV/DIVU go through div_unit.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  ex_if
);

    logic is_div;
    logic div_stall;
    logic div_ready;
    reg_t div_quot;
    reg_t div_rem;
    reg_t hi_fwd;
    reg_t lo_fwd;
    reg_t logic_res;
    reg_t shift_res;
    reg_t move_res;

    assign is_div = (ex_if.aluop_i == EXE_DIV_OP) || (ex_if.aluop_i == EXE_DIVU_OP);

    // HI/LO being written by the instruction now in mem wins over the committed copy.
    assign hi_fwd = ex_if.mem_whilo_i ? ex_if.mem_hi_i : ex_if.hi_i;
    assign lo_fwd = ex_if.mem_whilo_i ? ex_if.mem_lo_i : ex_if.lo_i;

    div_unit #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (is_div),
        .signed_i   (ex_if.aluop_i == EXE_DIV_OP),
        .divzero_i  (ex_if.reg2_i == '0),
        .flush_i    (ex_if.flush_i),
        .dividend_i (ex_if.reg1_i),
        .divisor_i  (ex_if.reg2_i),
        .stall_o    (div_stall),
        .ready_o    (div_ready),
        .quot_o     (div_quot),
        .rem_o      (div_rem)
    );

    always_comb begin
        case (ex_if.aluop_i)
            EXE_AND_OP: logic_res = ex_if.reg1_i & ex_if.reg2_i;
            EXE_OR_OP:  logic_res = ex_if.reg1_i | ex_if.reg2_i;
            EXE_XOR_OP: logic_res = ex_if.reg1_i ^ ex_if.reg2_i;
            EXE_NOR_OP: logic_res = ~(ex_if.reg1_i | ex_if.reg2_i);
            EXE_LUI_OP: logic_res = ex_if.reg2_i;
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        case (ex_if.aluop_i)
            EXE_SLL_OP: shift_res = ex_if.reg2_i << ex_if.reg1_i[4:0];
            EXE_SRL_OP: shift_res = ex_if.reg2_i >> ex_if.reg1_i[4:0];
            EXE_SRA_OP: shift_res = reg_t'($signed(ex_if.reg2_i) >>> ex_if.reg1_i[4:0]);
            default:    shift_res = '0;
        endcase
    end

    always_comb begin
        case (ex_if.aluop_i)
            EXE_MFHI_OP: move_res = hi_fwd;
            EXE_MFLO_OP: move_res = lo_fwd;
            default:     move_res = '0;
        endcase
    end

    always_comb begin
        ex_if.wd_o       = '0;
        ex_if.wreg_o     = 1'b0;
        ex_if.wdata_o    = '0;
        ex_if.whilo_o    = 1'b0;
        ex_if.hi_o       = '0;
        ex_if.lo_o       = '0;
        ex_if.stallreq_o = 1'b0;
        if (!rst) begin
            ex_if.wd_o   = ex_if.wd_i;
            // Divides only write HI/LO, never the GPR file.
            ex_if.wreg_o = ex_if.wreg_i & ~is_div;
            case (ex_if.alusel_i)
                EXE_RES_LOGIC: ex_if.wdata_o = logic_res;
                EXE_RES_SHIFT: ex_if.wdata_o = shift_res;
                EXE_RES_MOVE:  ex_if.wdata_o = move_res;
                default:       ex_if.wdata_o = '0;
            endcase
            ex_if.whilo_o    = div_ready;
            ex_if.hi_o       = div_ready ? div_rem : '0;
            ex_if.lo_o       = div_ready ? div_quot : '0;
            ex_if.stallreq_o = div_stall;
        end
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline.
- Consumes the decode stage's registered outputs (aluop, alusel, operands, destination, write enable), held in the id/ex register.
- Produces the register write-back triple for the ex/mem register; the same triple is fed back to decode as its ex bypass source.
- Adds HI/LO-producing DIV/DIVU via an iterative 1-bit-per-cycle divider that stalls the pipeline, plus MFHI/MFLO reads with mem-stage HI/LO forwarding.

Parameters:
- DIV_CYCLES, 32, number of divider iteration cycles (equals data width; not intended for other values).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- flush_i  in  1  cancel in-flight division (exception/branch kill)
- aluop_i  in  8  operation code (defines.v AluOpBus)
- alusel_i  in  3  result class (AluSelBus)
- reg1_i  in  32  operand 1 (rs value or shamt)
- reg2_i  in  32  operand 2 (rt value or immediate)
- wd_i  in  5  destination register
- wreg_i  in  1  register write enable
- hi_i, lo_i  in  32 each  committed HI/LO
- mem_whilo_i  in  1  mem stage writing HI/LO
- mem_hi_i, mem_lo_i  in  32 each  mem-stage HI/LO values
- wd_o  out  5  destination to ex/mem and decode bypass
- wreg_o  out  1  write enable to ex/mem and decode bypass
- wdata_o  out  32  result to ex/mem and decode bypass
- whilo_o  out  1  HI/LO write enable
- hi_o, lo_o  out  32 each  HI/LO write data
- stallreq_o  out  1  hold PC/if_id/id_ex while high

Behaviour:
- rst high:
  - All outputs are 0.
  - Divider state is IDLE, counter 0, datapath registers 0.
- Single-cycle ops, combinational, 0 latency:
  - AND/OR/XOR/NOR: bitwise on reg1_i, reg2_i.
  - LUI: wdata_o = reg2_i.
  - SLL: reg2_i << reg1_i[4:0].
  - SRL: logical right shift by reg1_i[4:0].
  - SRA: arithmetic right shift by reg1_i[4:0].
  - MFHI/MFLO: wdata_o = forwarded HI/LO, where mem_whilo_i selects mem_hi_i/mem_lo_i over hi_i/lo_i.
- Output selection:
  - wdata_o is selected by alusel_i; NOP, unknown, or DIV gives 0.
  - wd_o = wd_i.
  - wreg_o = wreg_i, except forced 0 for DIV/DIVU.
- Divider FSM states: IDLE, DIVZERO, ON, END.
  - IDLE:
    - aluop DIV/DIVU with reg2_i==0: stallreq_o=1, go to DIVZERO.
    - aluop DIV/DIVU with reg2_i!=0: stallreq_o=1, latch operands, cnt=0, go to ON.
    - For DIV, latch absolute values plus sign flags: quotient negative iff signs differ; remainder takes the dividend's sign.
  - DIVZERO: stallreq_o=1; result = 0; go to END next cycle.
  - ON:
    - stallreq_o=1; each cycle performs one restoring shift-subtract step; cnt increments.
    - When cnt reaches DIV_CYCLES, apply sign correction and go to END.
  - END:
    - stallreq_o=0; whilo_o=1, lo_o=quotient, hi_o=remainder.
    - Next cycle IDLE unconditionally; the pipeline advances in this cycle.
- Stall timing:
  - stallreq_o for a nonzero divide is high for exactly 1+DIV_CYCLES cycles (IDLE cycle + ON cycles).
  - stallreq_o for divide-by-zero is high for 2 cycles.
- Operand changes after the IDLE latch are ignored.
- flush_i high in any state: next state IDLE, cnt 0; stallreq_o and whilo_o low from the following cycle. No HI/LO write occurs for the killed division.
- rst overrides flush_i; rst mid-division behaves as flush and also clears outputs.
- Non-divide ops with state!=IDLE: impossible under a correct stall protocol; the FSM ignores aluop_i until END.
- whilo_o is 0 in all cycles except END.

Decomposition:
- defines.v holds:
  - new EXE_DIV_OP, EXE_DIVU_OP, EXE_MFHI_OP, EXE_MFLO_OP codes;
  - EXE_RES_MOVE alusel;
  - divider state encodings.
  - Existing AluOpBus/AluSelBus/RegBus widths are reused.
- One sub-module is natural: div_unit, holding the FSM, counter, and shift-subtract datapath, with start/signed/flush/divisor-zero inputs and ready/result outputs. The ex_stage top holds the combinational ALU and muxing.

Test Plan:
- OR with reg1=0x0000FF00, reg2=0x0F0F0F0F, wd=5, wreg=1 -> same cycle: wdata_o=0x0F0FFF0F, wd_o=5, wreg_o=1, stallreq_o=0.
- SRA with reg1=4, reg2=0x80000000 -> wdata_o=0xF8000000; SRL same operands -> 0x08000000.
- MFHI with hi_i=0x11, mem_whilo_i=1, mem_hi_i=0x22 -> wdata_o=0x22; mem_whilo_i=0 -> 0x11.
- DIVU 100/7 held -> stallreq_o high 33 cycles, then one cycle with whilo_o=1, lo_o=14, hi_o=2, stallreq_o=0, wreg_o=0.
- DIV 0xFFFFFFF9(-7)/2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 5/0 -> stall 2 cycles, then lo_o=hi_o=0 with whilo_o=1.
- DIVU 100/7, flush_i pulsed at stall cycle 10 -> next cycle stallreq_o=0, whilo_o never asserted. Repeat with rst pulse -> same, plus all outputs 0 during reset.
